float_add_issue_queue: RTL

// - Upstream issue stage for the single-operation FloatAdder: buffers operand pairs in a FIFO, issues one at a time, waits for result.
// - Adder holds one operation at a time; this block serialises requests, preserves order and returns results with a caller tag.
// - Sits between operand producers (valid/ready) and result consumers (valid/ready).

---
 rtl/float_add_issue_queue.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/float_add_issue_queue.sv
// float_add_issue_queue: buffers operand pairs in a FIFO and feeds them one at a time to the single-op FloatAdder.
// Define FADD_ISSUE_TIMEOUT_EN to abort an operation with a qNaN/OutError result when the adder never answers.
module float_add_issue_queue #(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             InValid,
    output logic             InReady,
    input  logic [31:0]      InOp1,
    input  logic [31:0]      InOp2,
    input  logic [TAG_W-1:0] InTag,
    output logic [31:0]      AddOp1,
    output logic [31:0]      AddOp2,
    output logic             AddInputValid,
    input  logic [31:0]      AddResult,
    input  logic             AddResultValid,
    output logic [31:0]      OutResult,
    output logic [TAG_W-1:0] OutTag,
    output logic             OutValid,
    input  logic             OutReady,
    output logic             OutError
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_params
        $error("float_add_issue_queue: DEPTH must be a power of 2 >= 2 and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    state_t state, next_state;

    logic [31:0]      fifo_op1 [DEPTH];
    logic [31:0]      fifo_op2 [DEPTH];
    logic [TAG_W-1:0] fifo_tag [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;

    logic [TAG_W-1:0] cur_tag;
    logic             prev_valid;
    logic             push, pop, empty, full;
    logic             rise, timeout, capture;
    logic [31:0]      capture_result;

    assign full          = (count == CNT_W'(DEPTH));
    assign empty         = (count == '0);
    assign InReady       = !full;
    assign push          = InValid && !full;
    assign rise          = AddResultValid && !prev_valid;
    assign AddInputValid = (state == ISSUE);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (push) begin
            fifo_op1[wr_ptr] <= InOp1;
            fifo_op2[wr_ptr] <= InOp2;
            fifo_tag[wr_ptr] <= InTag;
        end
    end

    // Resetting to 1 keeps a level held across reset (or left over from the previous op) from looking like a new result.
    always_ff @(posedge Clock) begin
        if (Reset) prev_valid <= 1'b1;
        else       prev_valid <= AddResultValid;
    end

`ifdef FADD_ISSUE_TIMEOUT_EN
    localparam int          TO_W = $clog2(TIMEOUT + 1);
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic [TO_W-1:0] wait_cnt;

    always_ff @(posedge Clock) begin
        if (Reset || state != WAIT) wait_cnt <= '0;
        else                        wait_cnt <= wait_cnt + TO_W'(1);
    end

    assign timeout        = (state == WAIT) && (wait_cnt == TO_W'(TIMEOUT - 1));
    assign capture_result = rise ? AddResult : QNAN;

    always_ff @(posedge Clock) begin
        if (Reset)        OutError <= 1'b0;
        else if (capture) OutError <= !rise;
    end
`else
    assign timeout        = 1'b0;
    assign capture_result = AddResult;
    assign OutError       = 1'b0;
`endif

    always_ff @(posedge Clock) begin
        if (Reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        pop        = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    next_state = ISSUE;
                end
            end
            ISSUE: next_state = WAIT;
            WAIT: begin
                if (rise || timeout) begin
                    capture    = 1'b1;
                    next_state = HOLD;
                end
            end
            HOLD: begin
                if (OutReady) begin
                    if (!empty) begin
                        pop        = 1'b1;
                        next_state = ISSUE;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Adder operands are only reloaded when a new head is popped, so they stay stable until capture.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            AddOp1  <= '0;
            AddOp2  <= '0;
            cur_tag <= '0;
        end else if (pop) begin
            AddOp1  <= fifo_op1[rd_ptr];
            AddOp2  <= fifo_op2[rd_ptr];
            cur_tag <= fifo_tag[rd_ptr];
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            OutResult <= '0;
            OutTag    <= '0;
            OutValid  <= 1'b0;
        end else if (capture) begin
            OutResult <= capture_result;
            OutTag    <= cur_tag;
            OutValid  <= 1'b1;
        end else if (state == HOLD && OutReady) begin
            OutValid  <= 1'b0;
        end
    end

endmodule
